// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg.sv -- shared types, op table and constants for the ALU self-test.
// Opcode values mirror the Opcode.vh definitions used by ALUdec.
package alu_bist_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct;
        logic       add_rshift_type;
    } op_entry_t;

    localparam op_entry_t OP_TABLE [16] = '{
        '{OPC_LUI,       3'b000, 1'b0},
        '{OPC_AUIPC,     3'b000, 1'b0},
        '{OPC_LOAD,      3'b000, 1'b0},
        '{OPC_STORE,     3'b000, 1'b0},
        '{OPC_BRANCH,    3'b000, 1'b0},
        '{OPC_ARI_RTYPE, 3'b000, 1'b0},
        '{OPC_ARI_RTYPE, 3'b001, 1'b0},
        '{OPC_ARI_RTYPE, 3'b010, 1'b0},
        '{OPC_ARI_RTYPE, 3'b011, 1'b0},
        '{OPC_ARI_RTYPE, 3'b100, 1'b0},
        '{OPC_ARI_RTYPE, 3'b101, 1'b0},
        '{OPC_ARI_RTYPE, 3'b110, 1'b0},
        '{OPC_ARI_RTYPE, 3'b111, 1'b0},
        '{OPC_ARI_RTYPE, 3'b000, 1'b1},
        '{OPC_ARI_RTYPE, 3'b101, 1'b1},
        '{OPC_ARI_ITYPE, 3'b101, 1'b1}
    };

    // Right-shifting Galois form: the shifted-out bit folds the tap mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] misr_next(
        input logic [31:0] sig,
        input logic [31:0] poly,
        input logic [31:0] din
    );
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ din;
    endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// alu_bist_lfsr.sv -- 32-bit Galois LFSR operand generator.
// Reset and load both return the register to its seed.
module alu_bist_lfsr
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/alu_bist.sv
// alu_bist.sv -- LFSR-driven ALU/ALUdec self-test with MISR signature compaction.
// Define ALU_BIST_CORNER_EN to prepend four directed SLT corner vectors.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2345,
    parameter logic [31:0] MISR_POLY   = DEF_MISR_POLY
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] ExpectedSig,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [6:0]  opcode,
    output logic [2:0]  funct,
    output logic        add_rshift_type,
    input  logic [31:0] ALU_result,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [31:0] Signature
);

    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    bist_state_e state_q, state_d;

    logic        start_run;
    logic        busy;
    logic        rnd_act;
    logic        last_vec;
    logic [15:0] vec_cnt_q;
    logic [31:0] sig_q;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    op_entry_t   op_sel;

    assign busy     = (state_q == ST_RUN);
    assign last_vec = (vec_cnt_q == LAST_VEC);
    assign op_sel   = OP_TABLE[vec_cnt_q[3:0]];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start only counts outside RUN; a pulse mid-run is dropped.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (rnd_act && last_vec) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vec_cnt_q <= '0;
        end else if (start_run) begin
            vec_cnt_q <= '0;
        end else if (rnd_act) begin
            vec_cnt_q <= vec_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sig_q <= '0;
        end else if (start_run) begin
            sig_q <= '0;
        end else if (busy) begin
            sig_q <= misr_next(sig_q, MISR_POLY, ALU_result);
        end
    end

    alu_bist_lfsr #(
        .SEED (SEED)
    ) u_lfsr_a (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .load    (start_run),
        .step    (rnd_act),
        .value   (lfsr_a)
    );

    alu_bist_lfsr #(
        .SEED (~SEED)
    ) u_lfsr_b (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .load    (start_run),
        .step    (rnd_act),
        .value   (lfsr_b)
    );

`ifdef ALU_BIST_CORNER_EN
    logic       corner_q;
    logic [1:0] cidx_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            corner_q <= 1'b0;
            cidx_q   <= '0;
        end else if (start_run) begin
            corner_q <= 1'b1;
            cidx_q   <= '0;
        end else if (busy && corner_q) begin
            cidx_q <= cidx_q + 2'd1;
            if (cidx_q == 2'd3) begin
                corner_q <= 1'b0;
            end
        end
    end

    // LFSRs and the random-vector counter hold while directed vectors play.
    assign rnd_act = busy & ~corner_q;

    always_comb begin
        A               = '0;
        B               = '0;
        opcode          = '0;
        funct           = '0;
        add_rshift_type = 1'b0;
        if (busy && corner_q) begin
            opcode = OPC_ARI_RTYPE;
            funct  = 3'b010;
            unique case (cidx_q)
                2'd0: begin
                    A = 32'h8000_0000;
                    B = 32'h0000_0001;
                end
                2'd1: begin
                    A = 32'hFFFF_FFFE;
                    B = 32'hFFFF_FFFF;
                end
                2'd2: begin
                    A = 32'h0000_000A;
                    B = 32'hFFFF_FFFF;
                end
                default: begin
                    A = 32'h7FFF_FFFF;
                    B = 32'h8000_0000;
                end
            endcase
        end else if (busy) begin
            A               = lfsr_a;
            B               = lfsr_b;
            opcode          = op_sel.opcode;
            funct           = op_sel.funct;
            add_rshift_type = op_sel.add_rshift_type;
        end
    end
`else
    assign rnd_act = busy;

    always_comb begin
        A               = '0;
        B               = '0;
        opcode          = '0;
        funct           = '0;
        add_rshift_type = 1'b0;
        if (busy) begin
            A               = lfsr_a;
            B               = lfsr_b;
            opcode          = op_sel.opcode;
            funct           = op_sel.funct;
            add_rshift_type = op_sel.add_rshift_type;
        end
    end
`endif

    assign Busy      = busy;
    assign Done      = (state_q == ST_DONE);
    assign Pass      = Done && (sig_q == ExpectedSig);
    assign Signature = sig_q;

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
- REQ-001: Parameter NUM_VECTORS, default 256, number of pseudo-random vectors per run (1..65535).
- REQ-002: Parameter SEED, default 32'hACE1_2345, LFSR_A seed; LFSR_B seed is ~SEED.
- REQ-003: Parameter MISR_POLY, default 32'h04C1_1DB7, signature feedback polynomial.
- REQ-004: Clock  input  1  sole clock; all state updates on rising edge.
- REQ-005: Reset_n  input  1  asynchronous, active-low reset.
- REQ-006: Start  input  1  request a self-test run; sampled only in IDLE or DONE.
- REQ-007: ExpectedSig  input  32  golden signature compared at run end.
- REQ-008: A, B  output  32 each  ALU operand stimulus.
- REQ-009: opcode  output  7, funct  output  3, add_rshift_type  output  1  ALUdec stimulus.
- REQ-010: ALU_result  input  32  combinational ALU Out for the current stimulus.
- REQ-011: Busy  output  1  high in RUN; Done  output  1  high in DONE.
- REQ-012: Pass  output  1  Signature==ExpectedSig, valid only while Done.
- REQ-013: Signature  output  32  current MISR state.

Function
- REQ-014: FSM states IDLE, RUN, DONE; IDLE->RUN on Start; RUN->DONE after last vector; DONE->RUN on Start; DONE otherwise holds.
- REQ-015: Start sampled at edge t: MISR, vector counter, both LFSRs reload; vector 0 driven during cycle t+1.
- REQ-016: Vector k driven for exactly one cycle (t+1+k); ALU_result compacted at the edge ending that cycle.
- REQ-017: MISR update: Signature <= {Signature[30:0],1'b0} ^ (Signature[31] ? MISR_POLY : 0) ^ ALU_result.
- REQ-018: A = LFSR_A, B = LFSR_B; both 32-bit Galois LFSRs, tap mask 32'h8020_0003, stepped once per vector.
- REQ-019: Op slot = k mod 16, from a fixed 16-entry table: LUI, AUIPC, LOAD, STORE, BRANCH, then OPC_ARI_RTYPE funct 0..7 with add_rshift_type 0, then funct 000 and 101 with add_rshift_type 1, then OPC_ARI_ITYPE funct 101 with add_rshift_type 1.
- REQ-020: Done asserts in cycle t+1+NUM_VECTORS (t+5+NUM_VECTORS with REQ-026), held until next Start.
- REQ-021: Start while Busy is ignored; no restart, counter unaffected.
- REQ-022: Outside RUN, A, B, opcode, funct, add_rshift_type are 0 and Signature holds.
- REQ-023: Pass is 0 whenever Done is 0.

Reset
- REQ-024: Reset_n low: state IDLE; Busy, Done, Pass, Signature, A, B, opcode, funct, add_rshift_type all 0; counters 0; LFSRs = seeds.
- REQ-025: Reset mid-run aborts immediately; no partial Done; next Start replays the identical sequence.

Configuration
- REQ-026: Macro ALU_BIST_CORNER_EN defined: 4 directed vectors precede random ones, all OPC_ARI_RTYPE funct 010 (SLT): (A,B) = (32'h8000_0000,1), (32'hFFFF_FFFE,32'hFFFF_FFFF), (10,32'hFFFF_FFFF), (32'h7FFF_FFFF,32'h8000_0000); LFSRs do not step during them.
- REQ-027: Macro undefined: only NUM_VECTORS random vectors; no corner logic present.

Structure
- REQ-028: Shared package holds FSM state encoding, op-table entry type, 16-entry op table, LFSR tap and default MISR_POLY constants; opcodes reuse existing Opcode.vh definitions.
- REQ-029: One sub-module alu_bist_lfsr (32-bit Galois, load/step inputs), instantiated twice.

Verification
- REQ-030: Reset_n low -> all outputs 0; release, no Start -> outputs remain 0 for 10 cycles.
- REQ-031: NUM_VECTORS=16, golden ALUdec+ALU, Start at edge 0 -> vector 0 opcode=OPC_LUI, A=32'hACE1_2345, B=32'h531E_DCBA; Done at cycle 17; Signature equals bench model; ExpectedSig=model -> Pass=1.
- REQ-032: Same run, ALU_result bit 0 forced 0 -> Signature differs from model, Pass=0.
- REQ-033: Start pulsed at vector 5 while Busy -> ignored; Done still at cycle 17, same Signature.
- REQ-034: Reset_n low at vector 5, then Start -> full 16-vector run, Signature identical to REQ-031.
- REQ-035: ALU_BIST_CORNER_EN defined, NUM_VECTORS=16 -> first 4 vectors SLT with REQ-026 operands, ALU results 1,1,0,0; Done at cycle 21.
